// File: rtl/mux_2.sv
// -----------------------------------------------------------------------------
// mux_2 : two-input WIDTH-bit word selector with a registered tap and
//         select-activity monitoring.
//
// Ports
//   clk           in   1      single clock, all state updates on rising edge
//   reset         in   1      synchronous, active-high reset
//   a             in   WIDTH  data word selected when s = 0
//   b             in   WIDTH  data word selected when s = 1
//   s             in   1      select (must be a clean 0/1)
//   y             out  WIDTH  combinational mux output, zero latency
//   y_q           out  WIDTH  registered copy of y, one-cycle latency
//   sel_toggle    out  1      one-cycle pulse after s differs from last edge
//   toggle_count  out  CNT_W  saturating count of select toggles
// -----------------------------------------------------------------------------
module mux_2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_toggle,
  output logic [CNT_W-1:0] toggle_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] ydata_q,  ydata_d;
  logic             s_prev_q, s_prev_d;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             toggle_s;

  // Raw selector: independent of clk and reset so it stays valid in reset.
  always_comb begin
    if (s == 1'b0) begin
      y = a;
    end else begin
      y = b;
    end
  end

  // A toggle is any difference between the current select and the one
  // captured at the previous edge.
  assign toggle_s = (s != s_prev_q);

  // Next-state logic; reset dominates so a toggle seen in a reset cycle is
  // dropped entirely (no pulse, no count).
  always_comb begin
    ydata_d  = ydata_q;
    s_prev_d = s_prev_q;
    toggle_d = toggle_q;
    count_d  = count_q;
    if (reset) begin
      ydata_d  = {WIDTH{1'b0}};
      s_prev_d = 1'b0;
      toggle_d = 1'b0;
      count_d  = {CNT_W{1'b0}};
    end else begin
      ydata_d  = y;
      s_prev_d = s;
      toggle_d = toggle_s;
      // Saturate at all-ones rather than wrapping back to zero.
      if (toggle_s && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // State register; reset handling lives in the next-state logic above.
  always_ff @(posedge clk) begin
    ydata_q  <= ydata_d;
    s_prev_q <= s_prev_d;
    toggle_q <= toggle_d;
    count_q  <= count_d;
  end

  assign y_q          = ydata_q;
  assign sel_toggle   = toggle_q;
  assign toggle_count = count_q;

endmodule

// File: tb/tb_mux_2.sv
module tb_mux_2;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic       s;

  logic [7:0] y8, yq8;
  logic       tog8;
  logic [7:0] cnt8;
  logic [7:0] y2, yq2;
  logic       tog2;
  logic [1:0] cnt2;

  int n_cmp;
  int n_bad;

  // reference model state (plain integers, spec-level rules)
  int m_prev;
  int m_yq;
  int m_tog;
  int m_cnt8;
  int m_cnt2;

  mux_2 #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .a(a), .b(b), .s(s),
    .y(y8), .y_q(yq8), .sel_toggle(tog8), .toggle_count(cnt8)
  );

  mux_2 #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .s(s),
    .y(y2), .y_q(yq2), .sel_toggle(tog2), .toggle_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v + 1 > maxv) ? maxv : v + 1;
  endfunction

  // Apply one cycle of inputs, check y before the edge, then the registered
  // outputs after it against the model.
  task automatic step(input logic [7:0] ai, input logic [7:0] bi,
                      input logic si, input logic ri);
    int exp_y;
    int t;
    a = ai; b = bi; s = si; reset = ri;
    exp_y = (si == 1'b0) ? int'(ai) : int'(bi);
    #1;
    check("y8", 32'(y8), 32'(exp_y));
    check("y2", 32'(y2), 32'(exp_y));
    @(posedge clk);
    if (ri) begin
      m_yq = 0; m_tog = 0; m_cnt8 = 0; m_cnt2 = 0; m_prev = 0;
    end else begin
      t      = (int'(si) != m_prev) ? 1 : 0;
      m_yq   = exp_y;
      m_tog  = t;
      if (t == 1) begin
        m_cnt8 = sat_inc(m_cnt8, 255);
        m_cnt2 = sat_inc(m_cnt2, 3);
      end
      m_prev = int'(si);
    end
    #1;
    check("yq8",  32'(yq8),  32'(m_yq));
    check("yq2",  32'(yq2),  32'(m_yq));
    check("tog8", 32'(tog8), 32'(m_tog));
    check("tog2", 32'(tog2), 32'(m_tog));
    check("cnt8", 32'(cnt8), 32'(m_cnt8));
    check("cnt2", 32'(cnt2), 32'(m_cnt2));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_prev = 0; m_yq = 0; m_tog = 0; m_cnt8 = 0; m_cnt2 = 0;
    a = 8'd0; b = 8'd0; s = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // reset state
    step(8'd0, 8'd0, 1'b0, 1'b1);
    check("rst_yq", 32'(yq8), 32'd0);
    check("rst_cnt", 32'(cnt8), 32'd0);

    // 1: s=0 selects a
    step(8'd2, 8'd14, 1'b0, 1'b0);
    check("t1_y", 32'(y8), 32'd2);
    check("t1_yq", 32'(yq8), 32'd2);
    check("t1_cnt", 32'(cnt8), 32'd0);

    // 2: s=1 selects b, one toggle pulse
    step(8'd2, 8'd14, 1'b1, 1'b0);
    check("t2_yq", 32'(yq8), 32'd14);
    check("t2_tog", 32'(tog8), 32'd1);
    check("t2_cnt", 32'(cnt8), 32'd1);
    step(8'd2, 8'd14, 1'b1, 1'b0);
    check("t2_pulse_end", 32'(tog8), 32'd0);

    // 3: back to s=0, then change a with s held
    step(8'd2, 8'd14, 1'b0, 1'b0);
    check("t3_cnt", 32'(cnt8), 32'd2);
    step(8'd1, 8'd14, 1'b0, 1'b0);
    check("t3_y", 32'(y8), 32'd1);
    check("t3_notog", 32'(tog8), 32'd0);
    check("t3_cnt_hold", 32'(cnt8), 32'd2);

    // 4: saturation of the 2-bit counter
    step(8'd5, 8'd9, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(8'd5, 8'd9, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    check("t4_sat2", 32'(cnt2), 32'd3);
    check("t4_cnt8", 32'(cnt8), 32'd6);

    // 5: reset coincident with a select change
    step(8'h3c, 8'hc3, 1'b1, 1'b0);
    step(8'h3c, 8'hc3, 1'b0, 1'b1);
    check("t5_y", 32'(y8), 32'h3c);
    check("t5_yq", 32'(yq8), 32'd0);
    check("t5_tog", 32'(tog8), 32'd0);
    check("t5_cnt", 32'(cnt8), 32'd0);
    // first cycle after reset: s=1 counts against the cleared history
    step(8'h3c, 8'hc3, 1'b1, 1'b0);
    check("t5_post_tog", 32'(tog8), 32'd1);
    check("t5_post_cnt", 32'(cnt8), 32'd1);

    // 6: random traffic with occasional reset
    for (int i = 0; i < 1000; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
